nvme_cq_snoop: RTL and testbench
================================

# nvme_cq_snoop

Multi-queue NVMe completion-queue snooper with phase tracking and buffered CQE output. It watches the AXI write channel that the SSD uses to post completion entries into on-chip memory. It assembles each 16-byte CQE from DW0, DW2 and DW3 for up to NUM_CQ queues, and checks the phase tag and slot order for each queue. Accepted entries go into an internal FWFT FIFO behind a valid/ready port. Every pop produces a doorbell head-update pulse for the doorbell writer.

## Interface
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 32, snooped W width; legal values are 32 and 64
- NUM_CQ, 4, number of tracked queues (1..8); queue 0 is the admin CQ
- CQ_BASE, {32'ha010_7000, 32'ha010_6000, 32'ha010_3000, 32'ha010_1000}, packed NUM_CQ×ADDR_WIDTH; each entry is 4 KiB aligned; queue q occupies slice q
- CQ_ENTRIES, 64, entries per queue; power of 2, max 256
- FIFO_DEPTH, 512, CQE FIFO depth; power of 2
- AF_MARGIN, 8, almost-full threshold margin
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- awvalid, awready  in  1  AW handshake (snoop only)
- awaddr  in  ADDR_WIDTH  burst start address
- wvalid, wready  in  1  W handshake (snoop only)
- wdata  in  DATA_WIDTH  write beat
- q_reset  in  NUM_CQ  per-queue sync reinit pulse: tail=0, head=0, phase=1
- err_clear  in  1  pulse that clears sticky errors and counters
- cqe_valid  out  1  FIFO head valid
- cqe_ready  in  1  consumer accept
- cqe_qid, cqe_idx  out  3, 8  queue id, slot index
- cqe_dw0  out  32  command-specific field
- cqe_sqhd, cqe_sqid, cqe_cid  out  16 each  CQE DW2[15:0], DW2[31:16], DW3[15:0]
- cqe_status  out  15  DW3[31:17]
- hd_upd_valid  out  1  one-cycle head-update pulse
- hd_upd_qid, hd_upd_head  out  3, 8  queue and new head value
- fifo_afull  out  1  asserted when count ≥ FIFO_DEPTH−AF_MARGIN
- phase_err, seq_err  out  NUM_CQ  sticky per-queue error flags
- ovf  out  1  sticky overflow flag
- drop_cnt  out  16  dropped entries, saturating

## Operation
- Address tracking:
  - On AW handshake, load addr_q ← awaddr.
  - On each W handshake, beat address = addr_q (or awaddr if AW handshakes in the same cycle), then addr_q += DATA_WIDTH/8.
  - One outstanding AW is supported.
- Queue match: beat address [ADDR_WIDTH-1:12] == CQ_BASE[q][ADDR_WIDTH-1:12] and slot = addr[11:4] < CQ_ENTRIES. Non-matching beats are ignored.
- Assembly at DATA_WIDTH=32: offset 0x0 → DW0, 0x8 → DW2, 0xC → DW3 (completes the entry). 0x4 is ignored.
- Assembly at DATA_WIDTH=64: offset 0x0 → DW0 from [31:0]; offset 0x8 → DW2 from [31:0] and DW3 from [63:32] (completes the entry).
- On completion, entry_stb is registered together with the queue, slot and fields.
- Per-queue state: exp_tail and exp_phase (reset value 1).
  - Phase check: if DW3[16] ≠ exp_phase[q], set phase_err[q] and drop the entry. The drop does not increment drop_cnt, and tail/phase are unchanged.
  - Otherwise, if slot ≠ exp_tail[q], set seq_err[q]; the entry is still accepted.
  - On accept: exp_tail ← slot+1 mod CQ_ENTRIES. exp_phase toggles when slot = CQ_ENTRIES−1.
- FIFO push on accept:
  - If the FIFO is full, drop the entry, set ovf, and drop_cnt++ (saturates at 16'hFFFF).
  - A push and a pop in the same cycle while full is not a drop.
- Pop (cqe_valid && cqe_ready): hd_upd_valid=1 next cycle, with hd_upd_qid=cqe_qid and hd_upd_head=(cqe_idx+1) mod CQ_ENTRIES.
- q_reset[q] behaviour:
  - Takes priority over a same-cycle completion on queue q; that entry is discarded without a flag.
  - Does not flush FIFO contents.
- err_clear clears phase_err, seq_err, ovf and drop_cnt. A same-cycle set wins over the clear.

## Timing
- Reset values:
  - All flags, drop_cnt, hd_upd_* and cqe_valid are 0.
  - cqe_* data is 0.
  - exp_phase is all 1s and exp_tail is 0.
  - fifo_afull is 0.
- Completing beat handshake in cycle N: entry_stb in N+1, FIFO write at the end of N+1, cqe_valid=1 in N+2 (FWFT from empty). Error flags are visible in N+2.
- Throughput is one CQE per beat pair at 64-bit and one per 4 beats at 32-bit; there are no stalls. The snoop never drives awready or wready.
- cqe_* data is held stable while cqe_valid && !cqe_ready.
- Reset asserted mid-burst: all state clears immediately; the partial CQE is lost.

## Structure
- Package nvme_cq_pkg holds:
  - CQE offset constants (DW0 0x0, DW2 0x8, DW3 0xC)
  - the phase bit index (16)
  - the cqe_t packed struct (qid, idx, dw0, sqhd, sqid, cid, status)
  - CQE_W = $bits(cqe_t)
- Sub-module nvme_sync_fifo: parametric width/depth, FWFT, with count, full and empty outputs and asynchronous active-low reset.

## Test plan
- Q1 (base 0xa010_3000), 32-bit, AW 0xa010_3000, 4 beats with DW3=0x0001_0007 → cqe_valid in cycle N+2 with qid=1, idx=0, cid=7, status=0; after pop, hd_upd_head=1.
- 64 entries written to Q0 with phase 1, then slot 0 rewritten with phase 0 → 65 entries accepted, no errors; the 65th has idx=0.
- Slot 1 written to Q2 with phase=0 immediately after reset → entry dropped, phase_err[2]=1, drop_cnt=0.
- Q3 slots 0 then 2 → both accepted, seq_err[3]=1, exp_tail=3.
- cqe_ready held 0 through 513 entries → ovf=1, drop_cnt=1; fifo_afull high from count 504.
- q_reset[1] in the same cycle as a Q1 DW3 beat → no push, exp_tail[1]=0, exp_phase[1]=1; aresetn pulsed mid-burst → all outputs return to reset values.

Source files
------------

// File: rtl/nvme_cq_pkg.sv
// Purpose: shared constants and the CQE record type for the NVMe completion-queue snooper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package nvme_cq_pkg;

    // Byte offsets of the captured dwords inside a 16-byte completion entry
    localparam logic [3:0] OFF_DW0 = 4'h0;
    localparam logic [3:0] OFF_DW2 = 4'h8;
    localparam logic [3:0] OFF_DW3 = 4'hC;

    // Phase tag position inside DW3
    localparam int PHASE_BIT = 16;

    typedef struct packed {
        logic [2:0]  qid;
        logic [7:0]  idx;
        logic [31:0] dw0;
        logic [15:0] sqhd;
        logic [15:0] sqid;
        logic [15:0] cid;
        logic [14:0] status;
    } cqe_t;

    localparam int CQE_W = $bits(cqe_t);

    // Next slot in a power-of-two ring of 'entries' slots (entries <= 256)
    function automatic logic [7:0] slot_inc(input logic [7:0] slot, input int entries);
        return 8'(slot + 8'd1) & 8'(entries - 1);
    endfunction

endpackage

// File: rtl/nvme_sync_fifo.sv
// Purpose: generic single-clock first-word-fall-through FIFO with occupancy count.
// Latency: a write is visible on rd_dat/!empty the cycle after it is accepted.
// Backpressure: writes while full are discarded unless a read happens in the same cycle.
//
// Ports: clk, rst_n (async active-low); wr_en/wr_dat write side; rd_en pops the
// head shown on rd_dat (all-zero while empty); count, full, empty status.
module nvme_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_dat,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign do_rd = rd_en && !empty;
    // A simultaneous pop frees the slot, so a write while full is still taken
    assign do_wr = wr_en && (!full || do_rd);

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Masked so the head reads as zero out of reset and whenever empty
    assign rd_dat = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/nvme_cq_snoop.sv
// Purpose: snoops AXI writes of NVMe completion entries, checks phase/slot order per queue, buffers CQEs.
// Latency: completing W beat in cycle N -> entry check in N+1 -> cqe_valid in N+2 (from empty).
// Backpressure: never stalls AXI; cqe_ready backpressure fills the FIFO, then entries are dropped and counted.
//
// Ports: aclk/aresetn; AW/W snoop inputs (awvalid, awready, awaddr, wvalid, wready, wdata);
// q_reset per-queue reinit, err_clear; cqe_* valid/ready output record; hd_upd_* head-update pulse;
// fifo_afull, per-queue sticky phase_err/seq_err, sticky ovf and saturating drop_cnt.
module nvme_cq_snoop
    import nvme_cq_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CQ     = 4,
    parameter logic [NUM_CQ*ADDR_WIDTH-1:0] CQ_BASE =
        {32'ha010_7000, 32'ha010_6000, 32'ha010_3000, 32'ha010_1000},
    parameter int CQ_ENTRIES = 64,
    parameter int FIFO_DEPTH = 512,
    parameter int AF_MARGIN  = 8
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  awvalid,
    input  logic                  awready,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic                  wvalid,
    input  logic                  wready,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [NUM_CQ-1:0]     q_reset,
    input  logic                  err_clear,
    output logic                  cqe_valid,
    input  logic                  cqe_ready,
    output logic [2:0]            cqe_qid,
    output logic [7:0]            cqe_idx,
    output logic [31:0]           cqe_dw0,
    output logic [15:0]           cqe_sqhd,
    output logic [15:0]           cqe_sqid,
    output logic [15:0]           cqe_cid,
    output logic [14:0]           cqe_status,
    output logic                  hd_upd_valid,
    output logic [2:0]            hd_upd_qid,
    output logic [7:0]            hd_upd_head,
    output logic                  fifo_afull,
    output logic [NUM_CQ-1:0]     phase_err,
    output logic [NUM_CQ-1:0]     seq_err,
    output logic                  ovf,
    output logic [15:0]           drop_cnt
);

    localparam int               BEAT_BYTES = DATA_WIDTH / 8;
    // The beat that carries DW3 finishes the entry
    localparam logic [3:0]       OFF_LAST   = (DATA_WIDTH == 64) ? OFF_DW2 : OFF_DW3;
    localparam logic [8:0]       SLOT_LIM   = 9'(CQ_ENTRIES);
    localparam logic [7:0]       LAST_SLOT  = 8'(CQ_ENTRIES - 1);
    localparam int               CNT_W      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] AF_LEVEL   = CNT_W'(FIFO_DEPTH - AF_MARGIN);

    // ------------------------------------------------------------------
    // Beat address tracking (single outstanding AW)
    // ------------------------------------------------------------------
    logic                  aw_hs;
    logic                  w_hs;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] beat_addr;

    assign aw_hs     = awvalid && awready;
    assign w_hs      = wvalid && wready;
    assign beat_addr = aw_hs ? awaddr : addr_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            addr_q <= '0;
        end else if (w_hs) begin
            addr_q <= beat_addr + ADDR_WIDTH'(BEAT_BYTES);
        end else if (aw_hs) begin
            addr_q <= awaddr;
        end
    end

    // ------------------------------------------------------------------
    // Queue match and per-queue partial-entry capture
    // ------------------------------------------------------------------
    logic        hit;
    logic [2:0]  hit_q;
    logic [7:0]  beat_slot;
    logic [3:0]  beat_off;
    logic [63:0] wd64;
    logic [31:0] dw0_buf [NUM_CQ];
    logic [31:0] dw2_buf [NUM_CQ];
    logic [31:0] sel_dw0;
    logic [31:0] sel_dw2;
    logic        beat_qr;
    logic        beat_ok;
    logic        is_dw0;
    logic        is_dw2;
    logic        is_last;

    assign beat_slot = beat_addr[11:4];
    assign beat_off  = beat_addr[3:0];
    assign wd64      = 64'(wdata);

    always_comb begin
        hit   = 1'b0;
        hit_q = '0;
        // Descending scan so the lowest matching queue wins
        for (int q = NUM_CQ - 1; q >= 0; q--) begin
            if (beat_addr[ADDR_WIDTH-1:12] == CQ_BASE[q*ADDR_WIDTH+12 +: ADDR_WIDTH-12]) begin
                hit   = 1'b1;
                hit_q = 3'(q);
            end
        end
        if ({1'b0, beat_slot} >= SLOT_LIM) begin
            hit = 1'b0;
        end
    end

    always_comb begin
        sel_dw0 = '0;
        sel_dw2 = '0;
        beat_qr = 1'b0;
        for (int q = 0; q < NUM_CQ; q++) begin
            if (hit_q == 3'(q)) begin
                sel_dw0 = dw0_buf[q];
                sel_dw2 = dw2_buf[q];
                beat_qr = q_reset[q];
            end
        end
    end

    assign beat_ok = w_hs && hit;
    assign is_dw0  = beat_ok && (beat_off == OFF_DW0);
    assign is_dw2  = beat_ok && (DATA_WIDTH == 32) && (beat_off == OFF_DW2);
    // A queue reinit in the same cycle silently discards the finishing entry
    assign is_last = beat_ok && (beat_off == OFF_LAST) && !beat_qr;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int q = 0; q < NUM_CQ; q++) begin
                dw0_buf[q] <= '0;
                dw2_buf[q] <= '0;
            end
        end else begin
            for (int q = 0; q < NUM_CQ; q++) begin
                if (is_dw0 && hit_q == 3'(q)) dw0_buf[q] <= wd64[31:0];
                if (is_dw2 && hit_q == 3'(q)) dw2_buf[q] <= wd64[31:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered completed entry
    // ------------------------------------------------------------------
    logic        ent_stb;
    logic [2:0]  ent_q;
    logic [7:0]  ent_slot;
    logic [31:0] ent_dw0;
    logic [31:0] ent_dw2;
    logic [31:0] ent_dw3;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ent_stb  <= 1'b0;
            ent_q    <= '0;
            ent_slot <= '0;
            ent_dw0  <= '0;
            ent_dw2  <= '0;
            ent_dw3  <= '0;
        end else begin
            ent_stb <= is_last;
            if (is_last) begin
                ent_q    <= hit_q;
                ent_slot <= beat_slot;
                ent_dw0  <= sel_dw0;
                ent_dw2  <= (DATA_WIDTH == 64) ? wd64[31:0]  : sel_dw2;
                ent_dw3  <= (DATA_WIDTH == 64) ? wd64[63:32] : wd64[31:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Phase / order check against the per-queue expected tail
    // ------------------------------------------------------------------
    logic [7:0]        exp_tail [NUM_CQ];
    logic [NUM_CQ-1:0] exp_phase;
    logic [7:0]        cur_tail;
    logic              cur_phase;
    logic              ent_qr;
    logic              chk;
    logic              acc;
    logic              pop;
    logic              drop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_cnt;
    logic [NUM_CQ-1:0] ph_set;
    logic [NUM_CQ-1:0] sq_set;
    logic [15:0]       drop_cnt_nxt;

    always_comb begin
        cur_tail  = '0;
        cur_phase = 1'b1;
        ent_qr    = 1'b0;
        for (int q = 0; q < NUM_CQ; q++) begin
            if (ent_q == 3'(q)) begin
                cur_tail  = exp_tail[q];
                cur_phase = exp_phase[q];
                ent_qr    = q_reset[q];
            end
        end
    end

    assign chk  = ent_stb && !ent_qr;
    assign acc  = chk && (ent_dw3[PHASE_BIT] == cur_phase);
    assign pop  = cqe_valid && cqe_ready;
    assign drop = acc && fifo_full && !pop;

    always_comb begin
        ph_set = '0;
        sq_set = '0;
        for (int q = 0; q < NUM_CQ; q++) begin
            if (ent_q == 3'(q)) begin
                ph_set[q] = chk && (ent_dw3[PHASE_BIT] != cur_phase);
                sq_set[q] = acc && (ent_slot != cur_tail);
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            exp_phase <= '1;
            for (int q = 0; q < NUM_CQ; q++) begin
                exp_tail[q] <= '0;
            end
        end else begin
            for (int q = 0; q < NUM_CQ; q++) begin
                if (q_reset[q]) begin
                    exp_tail[q]  <= '0;
                    exp_phase[q] <= 1'b1;
                end else if (acc && ent_q == 3'(q)) begin
                    exp_tail[q] <= slot_inc(ent_slot, CQ_ENTRIES);
                    if (ent_slot == LAST_SLOT) begin
                        exp_phase[q] <= ~exp_phase[q];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky errors and drop counter; a same-cycle set beats err_clear
    // ------------------------------------------------------------------
    always_comb begin
        drop_cnt_nxt = err_clear ? 16'h0000 : drop_cnt;
        if (drop && drop_cnt_nxt != 16'hFFFF) begin
            drop_cnt_nxt = drop_cnt_nxt + 16'd1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            phase_err <= '0;
            seq_err   <= '0;
            ovf       <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            phase_err <= (err_clear ? '0 : phase_err) | ph_set;
            seq_err   <= (err_clear ? '0 : seq_err) | sq_set;
            ovf       <= (err_clear ? 1'b0 : ovf) | drop;
            drop_cnt  <= drop_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // CQE buffer
    // ------------------------------------------------------------------
    cqe_t             push_cqe;
    cqe_t             head_cqe;
    logic [CQE_W-1:0] head_raw;

    always_comb begin
        push_cqe.qid    = ent_q;
        push_cqe.idx    = ent_slot;
        push_cqe.dw0    = ent_dw0;
        push_cqe.sqhd   = ent_dw2[15:0];
        push_cqe.sqid   = ent_dw2[31:16];
        push_cqe.cid    = ent_dw3[15:0];
        push_cqe.status = ent_dw3[31:17];
    end

    nvme_sync_fifo #(
        .WIDTH (CQE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (aclk),
        .rst_n  (aresetn),
        .wr_en  (acc),
        .wr_dat (push_cqe),
        .rd_en  (cqe_ready),
        .rd_dat (head_raw),
        .count  (fifo_cnt),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign head_cqe   = head_raw;
    assign cqe_valid  = !fifo_empty;
    assign cqe_qid    = head_cqe.qid;
    assign cqe_idx    = head_cqe.idx;
    assign cqe_dw0    = head_cqe.dw0;
    assign cqe_sqhd   = head_cqe.sqhd;
    assign cqe_sqid   = head_cqe.sqid;
    assign cqe_cid    = head_cqe.cid;
    assign cqe_status = head_cqe.status;
    assign fifo_afull = (fifo_cnt >= AF_LEVEL);

    // ------------------------------------------------------------------
    // Doorbell head update, one cycle after each pop
    // ------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            hd_upd_valid <= 1'b0;
            hd_upd_qid   <= '0;
            hd_upd_head  <= '0;
        end else begin
            hd_upd_valid <= pop;
            if (pop) begin
                hd_upd_qid  <= head_cqe.qid;
                hd_upd_head <= slot_inc(head_cqe.idx, CQ_ENTRIES);
            end
        end
    end

endmodule

// File: tb/tb_nvme_cq_snoop.sv
module tb_nvme_cq_snoop;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic        wvalid, wready;
    logic [31:0] wdata;
    logic [3:0]  q_reset;
    logic        err_clear;
    logic        cqe_valid, cqe_ready;
    logic [2:0]  cqe_qid;
    logic [7:0]  cqe_idx;
    logic [31:0] cqe_dw0;
    logic [15:0] cqe_sqhd, cqe_sqid, cqe_cid;
    logic [14:0] cqe_status;
    logic        hd_upd_valid;
    logic [2:0]  hd_upd_qid;
    logic [7:0]  hd_upd_head;
    logic        fifo_afull;
    logic [3:0]  phase_err, seq_err;
    logic        ovf;
    logic [15:0] drop_cnt;

    int total = 0;
    int bad   = 0;

    always #5 aclk = ~aclk;

    nvme_cq_snoop dut (
        .aclk(aclk), .aresetn(aresetn),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata),
        .q_reset(q_reset), .err_clear(err_clear),
        .cqe_valid(cqe_valid), .cqe_ready(cqe_ready),
        .cqe_qid(cqe_qid), .cqe_idx(cqe_idx), .cqe_dw0(cqe_dw0),
        .cqe_sqhd(cqe_sqhd), .cqe_sqid(cqe_sqid), .cqe_cid(cqe_cid),
        .cqe_status(cqe_status),
        .hd_upd_valid(hd_upd_valid), .hd_upd_qid(hd_upd_qid), .hd_upd_head(hd_upd_head),
        .fifo_afull(fifo_afull), .phase_err(phase_err), .seq_err(seq_err),
        .ovf(ovf), .drop_cnt(drop_cnt)
    );

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic aw, input logic [31:0] a, input logic [31:0] d);
        awvalid = aw;
        awaddr  = a;
        wvalid  = 1'b1;
        wdata   = d;
        tick();
        awvalid = 1'b0;
        wvalid  = 1'b0;
    endtask

    // Four 32-bit beats; returns in the cycle after the DW3 beat (N+1)
    task automatic write_cqe(input logic [31:0] a, input logic [31:0] dw0,
                             input logic [31:0] dw2, input logic [31:0] dw3,
                             input logic [3:0] qr);
        beat(1'b1, a, dw0);
        beat(1'b0, 32'h0, 32'hdead_beef);
        beat(1'b0, 32'h0, dw2);
        q_reset = qr;
        beat(1'b0, 32'h0, dw3);
        q_reset = 4'b0;
    endtask

    function automatic logic [31:0] dw3f(input logic ph, input logic [15:0] cid);
        return {15'h0, ph, cid};
    endfunction

    int   t;
    logic p;

    initial begin
        aresetn = 1'b0; awvalid = 1'b0; awready = 1'b1; awaddr = '0;
        wvalid = 1'b0; wready = 1'b1; wdata = '0;
        q_reset = '0; err_clear = 1'b0; cqe_ready = 1'b0;
        tick(); tick();
        aresetn = 1'b1;
        tick();

        // Reset state
        check("rst_valid", cqe_valid, 0);
        check("rst_hdupd", hd_upd_valid, 0);
        check("rst_phase_err", phase_err, 0);
        check("rst_seq_err", seq_err, 0);
        check("rst_ovf", ovf, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_afull", fifo_afull, 0);
        check("rst_cid", cqe_cid, 0);
        check("rst_dw0", cqe_dw0, 0);

        // Q1 single entry, latency and fields
        write_cqe(32'ha010_3000, 32'h1234_5678, 32'h0005_0001, 32'h0001_0007, 4'b0);
        check("lat_n1_valid", cqe_valid, 0);
        tick();
        check("lat_n2_valid", cqe_valid, 1);
        check("q1_qid", cqe_qid, 1);
        check("q1_idx", cqe_idx, 0);
        check("q1_cid", cqe_cid, 7);
        check("q1_status", cqe_status, 0);
        check("q1_dw0", cqe_dw0, 32'h1234_5678);
        check("q1_sqhd", cqe_sqhd, 1);
        check("q1_sqid", cqe_sqid, 5);
        cqe_ready = 1'b1;
        tick();
        cqe_ready = 1'b0;
        check("q1_hd_valid", hd_upd_valid, 1);
        check("q1_hd_qid", hd_upd_qid, 1);
        check("q1_hd_head", hd_upd_head, 1);
        check("q1_empty", cqe_valid, 0);
        tick();
        check("q1_hd_pulse", hd_upd_valid, 0);

        // Q0: 64 entries phase 1, then slot 0 again with phase 0
        for (int i = 0; i < 65; i++) begin
            write_cqe(32'ha010_1000 + 32'((i % 64) * 16), 32'(i), 32'h0,
                      dw3f((i < 64) ? 1'b1 : 1'b0, 16'(i)), 4'b0);
        end
        tick();
        check("wrap_phase_err", phase_err, 0);
        check("wrap_seq_err", seq_err, 0);
        check("wrap_afull", fifo_afull, 0);
        cqe_ready = 1'b1;
        for (int i = 0; i < 65; i++) begin
            check("wrap_valid", cqe_valid, 1);
            check("wrap_idx", cqe_idx, 32'(i % 64));
            check("wrap_cid", cqe_cid, 32'(i));
            tick();
        end
        cqe_ready = 1'b0;
        check("wrap_drained", cqe_valid, 0);
        check("wrap_hd_qid", hd_upd_qid, 0);
        check("wrap_hd_head", hd_upd_head, 1);

        // Q2 phase mismatch right after reset: dropped, not counted
        write_cqe(32'ha010_6010, 32'h0, 32'h0, dw3f(1'b0, 16'h0002), 4'b0);
        tick();
        check("ph_valid", cqe_valid, 0);
        check("ph_err", phase_err, 4'b0100);
        check("ph_drop", drop_cnt, 0);
        check("ph_seq", seq_err, 0);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("ph_clear", phase_err, 0);

        // Q3 slot 0 then slot 2: both accepted, order error
        write_cqe(32'ha010_7000, 32'h0, 32'h0, dw3f(1'b1, 16'h0030), 4'b0);
        write_cqe(32'ha010_7020, 32'h0, 32'h0, dw3f(1'b1, 16'h0032), 4'b0);
        tick();
        check("seq_err", seq_err, 4'b1000);
        check("seq_phase", phase_err, 0);
        cqe_ready = 1'b1;
        check("seq_idx0", cqe_idx, 0);
        tick();
        check("seq_idx2", cqe_idx, 2);
        check("seq_cid2", cqe_cid, 16'h0032);
        tick();
        cqe_ready = 1'b0;
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("seq_clear", seq_err, 0);
        // Expected tail is now 3: slot 3 must not flag
        write_cqe(32'ha010_7030, 32'h0, 32'h0, dw3f(1'b1, 16'h0033), 4'b0);
        tick();
        check("tail3_seq", seq_err, 0);
        check("tail3_valid", cqe_valid, 1);
        check("tail3_idx", cqe_idx, 3);
        cqe_ready = 1'b1;
        tick();
        cqe_ready = 1'b0;

        // Overflow: 513 entries into Q0 with no consumer (Q0 tail=1, phase=0)
        t = 1;
        p = 1'b0;
        for (int k = 0; k < 513; k++) begin
            write_cqe(32'ha010_1000 + 32'(t * 16), 32'(k), 32'h0, dw3f(p, 16'(k)), 4'b0);
            if (k == 503) check("afull_503", fifo_afull, 0);
            if (k == 504) check("afull_504", fifo_afull, 1);
            if (t == 63) p = ~p;
            t = (t + 1) % 64;
        end
        tick();
        check("ovf_flag", ovf, 1);
        check("ovf_drop", drop_cnt, 1);
        check("ovf_afull", fifo_afull, 1);
        check("ovf_phase", phase_err, 0);
        check("ovf_seq", seq_err, 0);
        check("ovf_head_idx", cqe_idx, 1);
        check("ovf_head_cid", cqe_cid, 0);
        cqe_ready = 1'b1;
        repeat (512) tick();
        cqe_ready = 1'b0;
        check("ovf_drained", cqe_valid, 0);
        check("ovf_afull_low", fifo_afull, 0);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("ovf_clear", ovf, 0);
        check("drop_clear", drop_cnt, 0);

        // q_reset on Q1 with the DW3 beat (Q1 tail was 1)
        write_cqe(32'ha010_3010, 32'h0, 32'h0, dw3f(1'b1, 16'h0011), 4'b0010);
        tick();
        check("qr_nopush", cqe_valid, 0);
        check("qr_seq", seq_err, 0);
        write_cqe(32'ha010_3000, 32'h0, 32'h0, dw3f(1'b1, 16'h0010), 4'b0);
        tick();
        check("qr_tail0_seq", seq_err, 0);
        check("qr_tail0_phase", phase_err, 0);
        check("qr_valid", cqe_valid, 1);
        check("qr_qid", cqe_qid, 1);
        check("qr_idx", cqe_idx, 0);
        cqe_ready = 1'b1;
        tick();
        cqe_ready = 1'b0;

        // Reset asserted mid-burst with state pending
        write_cqe(32'ha010_7040, 32'h0, 32'h0, dw3f(1'b0, 16'h0044), 4'b0);
        write_cqe(32'ha010_6000, 32'h0, 32'h0, dw3f(1'b1, 16'h0060), 4'b0);
        tick();
        check("pre_rst_phase", phase_err, 4'b1000);
        check("pre_rst_valid", cqe_valid, 1);
        beat(1'b1, 32'ha010_6010, 32'haaaa_aaaa);
        beat(1'b0, 32'h0, 32'h0);
        aresetn = 1'b0;
        #1;
        check("arst_valid", cqe_valid, 0);
        check("arst_phase", phase_err, 0);
        tick();
        aresetn = 1'b1;
        check("rst2_hdupd", hd_upd_valid, 0);
        check("rst2_afull", fifo_afull, 0);
        check("rst2_cid", cqe_cid, 0);
        check("rst2_ovf", ovf, 0);
        check("rst2_drop", drop_cnt, 0);
        // Rest of the interrupted burst has lost its address
        beat(1'b0, 32'h0, 32'h0);
        beat(1'b0, 32'h0, dw3f(1'b1, 16'h0061));
        tick();
        tick();
        check("rst2_partial_lost", cqe_valid, 0);
        write_cqe(32'ha010_6000, 32'h0, 32'h0, dw3f(1'b1, 16'h0077), 4'b0);
        tick();
        check("rst2_valid", cqe_valid, 1);
        check("rst2_qid", cqe_qid, 2);
        check("rst2_idx", cqe_idx, 0);
        check("rst2_cid", cqe_cid, 16'h0077);
        check("rst2_seq", seq_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
